lcd_bus_receiver: RTL

Receiving end of the HD44780-style 8-bit parallel LCD bus (`lcd_data`, `lcd_rs`, `lcd_en`) driven by the workout display controller. The block samples the bus on the system clock and decodes each enable strobe as either a command or a data write. It keeps a 2×16 shadow DDRAM, the cursor and display state, so on-chip logic or a loopback bench can read back exactly what the panel would show. It sits beside the LCD controller on `clk_sys` and is synthesizable.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_strobe_sync.sv | 95 +++++++++
 rtl/lcd_bus_receiver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state type and DDRAM address helpers for the LCD bus receiver.
package lcd_pkg;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_ENTRY    = 8'h04;
    localparam logic [7:0] OP_DISPCTL  = 8'h08;
    localparam logic [7:0] OP_SETDDRAM = 8'h80;

    localparam logic [7:0] LCD_BLANK  = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } lcd_state_t;

    // Line select is address bit 6; the low nibble is the column.
    function automatic logic [4:0] addr_to_idx(input logic [6:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

    function automatic logic [6:0] idx_to_addr(input logic [4:0] idx);
        return idx[4] ? (LINE2_BASE | {3'b000, idx[3:0]}) : {3'b000, idx[3:0]};
    endfunction

    function automatic logic addr_visible(input logic [6:0] addr);
        return addr[5:4] == 2'b00;
    endfunction

    function automatic logic [6:0] cursor_next(input logic [6:0] addr, input logic inc);
        logic [6:0] last1;
        logic [6:0] last2;
        last1 = 7'(LINE_LEN - 1);
        last2 = LINE2_BASE + 7'(LINE_LEN - 1);
        if (inc) begin
            if (addr == last1) return LINE2_BASE;
            if (addr == last2) return 7'h00;
            return addr + 7'd1;
        end
        if (addr == 7'h00)      return last2;
        if (addr == LINE2_BASE) return last1;
        return addr - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Synchronizes the LCD bus, holds the last en-high byte and emits one registered
// strobe per qualified falling edge of en.
module lcd_strobe_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int EN_MIN_HIGH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic [7:0] lcd_data,
    output logic       strobe,
    output logic       strobe_rs,
    output logic [7:0] strobe_byte
);

    localparam int CW = $clog2(EN_MIN_HIGH + 1);

    logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0]      rs_sync_q, rs_sync_d;
    logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
    logic                        en_prev_q, en_prev_d;
    logic                        hold_rs_q, hold_rs_d;
    logic [7:0]                  hold_byte_q, hold_byte_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        strobe_q, strobe_d;
    logic                        rs_q, rs_d;
    logic [7:0]                  byte_q, byte_d;

    logic en_s;
    logic fall;

    assign en_s = en_sync_q[SYNC_STAGES-1];
    assign fall = en_prev_q & ~en_s;

    always_comb begin
        en_sync_d      = en_sync_q;
        rs_sync_d      = rs_sync_q;
        data_sync_d    = data_sync_q;
        en_sync_d[0]   = lcd_en;
        rs_sync_d[0]   = lcd_rs;
        data_sync_d[0] = lcd_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            en_sync_d[i]   = en_sync_q[i-1];
            rs_sync_d[i]   = rs_sync_q[i-1];
            data_sync_d[i] = data_sync_q[i-1];
        end

        en_prev_d   = en_s;
        hold_rs_d   = hold_rs_q;
        hold_byte_d = hold_byte_q;
        cnt_d       = '0;
        if (en_s) begin
            hold_rs_d   = rs_sync_q[SYNC_STAGES-1];
            hold_byte_d = data_sync_q[SYNC_STAGES-1];
            cnt_d       = (cnt_q == CW'(EN_MIN_HIGH)) ? cnt_q : cnt_q + 1'b1;
        end

        // cnt_q still holds the high-run length in the cycle en is first seen low
        strobe_d = fall && (cnt_q == CW'(EN_MIN_HIGH));
        rs_d     = fall ? hold_rs_q : rs_q;
        byte_d   = fall ? hold_byte_q : byte_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_sync_q   <= '0;
            rs_sync_q   <= '0;
            data_sync_q <= '0;
            en_prev_q   <= 1'b0;
            hold_rs_q   <= 1'b0;
            hold_byte_q <= 8'h00;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            rs_q        <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            en_sync_q   <= en_sync_d;
            rs_sync_q   <= rs_sync_d;
            data_sync_q <= data_sync_d;
            en_prev_q   <= en_prev_d;
            hold_rs_q   <= hold_rs_d;
            hold_byte_q <= hold_byte_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            rs_q        <= rs_d;
            byte_q      <= byte_d;
        end
    end

    assign strobe      = strobe_q;
    assign strobe_rs   = rs_q;
    assign strobe_byte = byte_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style bus receiver: decodes strobes into a 2x16 shadow DDRAM plus
// cursor/display state, with a 32-cycle clear sweep.
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EN_MIN_HIGH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_en,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor,
    output logic       display_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       err_addr,
    output logic       err_overrun
);

    logic       s_strobe;
    logic       s_rs;
    logic [7:0] s_byte;

    lcd_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .EN_MIN_HIGH(EN_MIN_HIGH)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data),
        .strobe     (s_strobe),
        .strobe_rs  (s_rs),
        .strobe_byte(s_byte)
    );

    lcd_state_t state_q, state_d;
    logic [4:0] clr_idx_q, clr_idx_d;
    logic [6:0] cursor_q, cursor_d;
    logic       display_on_q, display_on_d;
    logic       entry_inc_q, entry_inc_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       cmd_rs_q, cmd_rs_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       err_addr_q, err_addr_d;
    logic       err_overrun_q, err_overrun_d;
    logic [7:0] rd_char_q, rd_char_d;
    logic [7:0] mem_q [32];

    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_data;

    always_comb begin
        state_d       = state_q;
        clr_idx_d     = clr_idx_q;
        cursor_d      = cursor_q;
        display_on_d  = display_on_q;
        entry_inc_d   = entry_inc_q;
        cmd_valid_d   = 1'b0;
        cmd_rs_d      = cmd_rs_q;
        cmd_byte_d    = cmd_byte_q;
        err_addr_d    = err_addr_q;
        err_overrun_d = err_overrun_q;
        rd_char_d     = mem_q[rd_addr];
        wr_en         = 1'b0;
        wr_idx        = 5'd0;
        wr_data       = LCD_BLANK;

        unique case (state_q)
            ST_IDLE: begin
                if (s_strobe) begin
                    cmd_valid_d = 1'b1;
                    cmd_rs_d    = s_rs;
                    cmd_byte_d  = s_byte;
                    if (s_rs) begin
                        if (addr_visible(cursor_q)) begin
                            wr_en   = 1'b1;
                            wr_idx  = addr_to_idx(cursor_q);
                            wr_data = s_byte;
                        end else begin
                            err_addr_d = 1'b1;
                        end
                        cursor_d = cursor_next(cursor_q, entry_inc_q);
                    end else if (|(s_byte & OP_SETDDRAM)) begin
                        cursor_d = s_byte[6:0];
                    end else if (s_byte >= 8'h10) begin
                        // shift, function set and CGRAM carry no shadow state
                    end else if (|(s_byte & OP_DISPCTL)) begin
                        display_on_d = s_byte[2];
                    end else if (|(s_byte & OP_ENTRY)) begin
                        entry_inc_d = s_byte[1];
                    end else if (|(s_byte & OP_HOME)) begin
                        cursor_d = 7'h00;
                    end else if (s_byte == OP_CLEAR) begin
                        state_d   = ST_CLEAR;
                        clr_idx_d = 5'd0;
                    end
                end
            end
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_idx    = clr_idx_q;
                wr_data   = LCD_BLANK;
                clr_idx_d = clr_idx_q + 5'd1;
                if (s_strobe) err_overrun_d = 1'b1;
                if (clr_idx_q == 5'd31) begin
                    state_d     = ST_IDLE;
                    cursor_d    = 7'h00;
                    entry_inc_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            clr_idx_q     <= 5'd0;
            cursor_q      <= 7'h00;
            display_on_q  <= 1'b0;
            entry_inc_q   <= 1'b1;
            cmd_valid_q   <= 1'b0;
            cmd_rs_q      <= 1'b0;
            cmd_byte_q    <= 8'h00;
            err_addr_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            rd_char_q     <= LCD_BLANK;
        end else begin
            state_q       <= state_d;
            clr_idx_q     <= clr_idx_d;
            cursor_q      <= cursor_d;
            display_on_q  <= display_on_d;
            entry_inc_q   <= entry_inc_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_rs_q      <= cmd_rs_d;
            cmd_byte_q    <= cmd_byte_d;
            err_addr_q    <= err_addr_d;
            err_overrun_q <= err_overrun_d;
            rd_char_q     <= rd_char_d;
        end
    end

    // Shadow DDRAM is flop-based so reset can blank every cell at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= LCD_BLANK;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_char     = rd_char_q;
    assign cursor      = cursor_q;
    assign display_on  = display_on_q;
    assign entry_inc   = entry_inc_q;
    assign busy        = (state_q == ST_CLEAR);
    assign cmd_valid   = cmd_valid_q;
    assign cmd_rs      = cmd_rs_q;
    assign cmd_byte    = cmd_byte_q;
    assign err_addr    = err_addr_q;
    assign err_overrun = err_overrun_q;

endmodule
